// File: rtl/load_store_unit.sv
// Load/store unit: checks the access, runs one bus transaction per accepted request, then extends load data.
// The FSM waits as long as needed for bus_gnt and bus_rvalid. stall holds the pipeline from acceptance through WAIT_R.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        access_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        access_error_q, access_error_d;

  logic        req_any, width_ok, align_ok, legal_req, bad_req;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext_data, wdata;
  logic [3:0]  wstrb;

  always_comb begin
    req_any  = mem_read_enable | mem_write_enable;
    // A simultaneous read and write is treated as a read.
    if (mem_read_enable)
      width_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    else
      width_ok = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
    case (funct3[1:0])
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal_req = (state_q == IDLE) && req_any && width_ok && align_ok;
    bad_req   = (state_q == IDLE) && req_any && !(width_ok && align_ok);
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    rbyte = bus_rdata[7:0];
      2'd1:    rbyte = bus_rdata[15:8];
      2'd2:    rbyte = bus_rdata[23:16];
      default: rbyte = bus_rdata[31:24];
    endcase
    rhalf = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   ext_data = {{24{rbyte[7] & ~funct3_q[2]}}, rbyte};
      2'b01:   ext_data = {{16{rhalf[15] & ~funct3_q[2]}}, rhalf};
      default: ext_data = bus_rdata;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        wdata = {4{sdata_q[7:0]}};
        wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        wdata = {2{sdata_q[15:0]}};
        wstrb = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: begin
        wdata = sdata_q;
        wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    sdata_d        = sdata_q;
    funct3_d       = funct3_q;
    we_d           = we_q;
    load_data_d    = load_data_q;
    load_valid_d   = 1'b0;
    access_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        access_error_d = bad_req;
        if (legal_req) begin
          addr_d   = addr;
          sdata_d  = store_data;
          funct3_d = funct3;
          we_d     = ~mem_read_enable;
          state_d  = REQ;
        end
      end
      REQ: if (bus_gnt) state_d = we_q ? DONE : WAIT_R;
      WAIT_R: if (bus_rvalid) begin
        load_data_d  = ext_data;
        load_valid_d = 1'b1;
        state_d      = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      sdata_q        <= '0;
      funct3_q       <= '0;
      we_q           <= 1'b0;
      load_data_q    <= '0;
      load_valid_q   <= 1'b0;
      access_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      sdata_q        <= sdata_d;
      funct3_q       <= funct3_d;
      we_q           <= we_d;
      load_data_q    <= load_data_d;
      load_valid_q   <= load_valid_d;
      access_error_q <= access_error_d;
    end
  end

  // The acceptance term is gated by rst_n so every output reads 0 while in reset.
  assign stall        = (state_q == REQ) || (state_q == WAIT_R) || (legal_req && rst_n);
  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign access_error = access_error_q;
  assign bus_req      = (state_q == REQ);
  assign bus_we       = bus_req & we_q;
  assign bus_addr     = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_wdata    = bus_we ? wdata : 32'h0;
  assign bus_wstrb    = bus_we ? wstrb : 4'h0;

endmodule
